// File: rtl/timeout_sequencer_if.sv
// Requester-side control/status bundle for timeout_sequencer.
interface timeout_sequencer_if #(
   parameter int CNT_W = 8
);
   logic             start_req;
   logic [CNT_W-1:0] period_count;
   logic             cancel;
   logic             start_ack;
   logic             busy;
   logic             done;
   logic [CNT_W-1:0] remaining;
   logic             err_stall;

   // Requester side (system control logic)
   modport master (
      output start_req, period_count, cancel,
      input  start_ack, busy, done, remaining, err_stall
   );

   // Sequencer side
   modport slave (
      input  start_req, period_count, cancel,
      output start_ack, busy, done, remaining, err_stall
   );
endinterface

// File: rtl/timeout_sequencer.sv
// Drives the 100 ms timer enable, counts returned ticks and reports completion
// after the requested number of periods; includes a stall watchdog.
module timeout_sequencer #(
   parameter int CNT_W        = 8,
   parameter int GUARD_W      = 24,
   parameter int GUARD_CYCLES = 12000000
) (
   input  logic                clk,
   input  logic                rst,
   timeout_sequencer_if.slave  bus,
   output logic                timer_enable,
   output logic                timer_clear,
   input  logic                tick
);

   typedef enum logic [2:0] {
      IDLE,
      ARM,
      RUN,
      DONE,
      FAULT
   } seqStateT;

   localparam logic [GUARD_W-1:0] GuardLast = GUARD_W'(GUARD_CYCLES - 1);

   seqStateT         state;
   seqStateT         stateNext;
   logic [CNT_W-1:0] remReg;
   logic [CNT_W-1:0] remNext;
   logic [GUARD_W-1:0] guardCnt;
   logic [GUARD_W-1:0] guardNext;
   logic             ackReg;
   logic             ackNext;

   // State, period counter, watchdog and accept flag registers
   always_ff @(posedge clk) begin
      if (!rst) begin
         state    <= IDLE;
         remReg   <= '0;
         guardCnt <= '0;
         ackReg   <= 1'b0;
      end else begin
         state    <= stateNext;
         remReg   <= remNext;
         guardCnt <= guardNext;
         ackReg   <= ackNext;
      end
   end

   // Next-state, period countdown and watchdog decisions
   always_comb begin
      stateNext = state;
      remNext   = remReg;
      guardNext = guardCnt;
      ackNext   = 1'b0;
      unique case (state)
         IDLE: begin
            if (bus.start_req) begin
               ackNext   = 1'b1;
               remNext   = bus.period_count;
               stateNext = (bus.period_count == '0) ? DONE : ARM;
            end
         end
         ARM: begin
            guardNext = '0;
            if (bus.cancel) begin
               remNext   = '0;
               stateNext = IDLE;
            end else begin
               stateNext = RUN;
            end
         end
         RUN: begin
            // cancel wins even over the final tick, so no done pulse follows
            if (bus.cancel) begin
               remNext   = '0;
               guardNext = '0;
               stateNext = IDLE;
            end else if (tick) begin
               remNext   = remReg - 1'b1;
               guardNext = '0;
               if (remReg == CNT_W'(1)) begin
                  stateNext = DONE;
               end
            end else if (guardCnt == GuardLast) begin
               stateNext = FAULT;
            end else begin
               guardNext = guardCnt + 1'b1;
            end
         end
         DONE: begin
            remNext   = '0;
            stateNext = IDLE;
         end
         FAULT: begin
            if (bus.cancel) begin
               remNext   = '0;
               stateNext = IDLE;
            end
         end
         default: begin
            remNext   = '0;
            guardNext = '0;
            stateNext = IDLE;
         end
      endcase
   end

   // The accept pulse is registered so the zero-period path (straight to DONE)
   // still acknowledges in the cycle after the request.
   assign bus.start_ack  = ackReg;
   assign timer_clear    = (state == ARM);
   assign timer_enable   = (state == RUN);
   assign bus.busy       = (state == ARM) || (state == RUN) || (state == DONE);
   assign bus.done       = (state == DONE);
   assign bus.err_stall  = (state == FAULT);
   assign bus.remaining  = remReg;

endmodule

// File: tb/tb_timeout_sequencer.sv
// Self-checking bench for timeout_sequencer: directed scenarios plus random
// traffic, compared every cycle against a transaction-level model.
module tb_timeout_sequencer;

   localparam int CNT   = 8;
   localparam int GUARD = 20;

   logic clk;
   logic rst;
   logic timer_enable;
   logic timer_clear;
   logic tick;

   timeout_sequencer_if #(.CNT_W(CNT)) bus ();

   timeout_sequencer #(
      .CNT_W        (CNT),
      .GUARD_W      (24),
      .GUARD_CYCLES (GUARD)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .bus          (bus),
      .timer_enable (timer_enable),
      .timer_clear  (timer_clear),
      .tick         (tick)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int errors = 0;
   int checks = 0;
   bit checkEn = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef enum int {P_IDLE, P_ARM, P_RUN, P_DONE, P_FAULT} phaseT;
   phaseT mPhase = P_IDLE;
   int    mRem   = 0;
   bit    mAck   = 1'b0;
   longint cyc   = 0;
   longint lastRef = 0;   // edge of run start or most recent tick

   always @(posedge clk) begin
      cyc++;
      if (!rst) begin
         mPhase = P_IDLE;
         mRem   = 0;
         mAck   = 1'b0;
      end else begin
         mAck = (mPhase == P_IDLE) && bus.start_req;
         case (mPhase)
            P_IDLE: if (bus.start_req) begin
               mRem   = int'(bus.period_count);
               mPhase = (mRem == 0) ? P_DONE : P_ARM;
            end
            P_ARM: if (bus.cancel) begin
               mPhase = P_IDLE; mRem = 0;
            end else begin
               mPhase = P_RUN; lastRef = cyc;
            end
            P_RUN: if (bus.cancel) begin
               mPhase = P_IDLE; mRem = 0;
            end else if (tick) begin
               mRem--; lastRef = cyc;
               if (mRem == 0) mPhase = P_DONE;
            end else if (cyc - lastRef >= GUARD) begin
               mPhase = P_FAULT;
            end
            P_DONE: mPhase = P_IDLE;
            P_FAULT: if (bus.cancel) begin
               mPhase = P_IDLE; mRem = 0;
            end
            default: mPhase = P_IDLE;
         endcase
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      if (checkEn) begin
         check("start_ack",    bus.start_ack, mAck);
         check("timer_clear",  timer_clear,   mPhase == P_ARM);
         check("timer_enable", timer_enable,  mPhase == P_RUN);
         check("busy",         bus.busy,      mPhase inside {P_ARM, P_RUN, P_DONE});
         check("done",         bus.done,      mPhase == P_DONE);
         check("err_stall",    bus.err_stall, mPhase == P_FAULT);
         check("remaining",    bus.remaining, mRem);
      end
   end

   // ---------------- stimulus ----------------
   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic startRun(input int n);
      bus.start_req    = 1'b1;
      bus.period_count = CNT'(n);
      cycle();
      check("lit_ack", bus.start_ack, 1);
      bus.start_req = 1'b0;
   endtask

   task automatic idleCycles(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic tickOnce();
      tick = 1'b1;
      cycle();
      tick = 1'b0;
   endtask

   int acks;
   int dones;
   int n;

   initial begin
      rst = 1'b0;
      tick = 1'b0;
      bus.start_req = 1'b0;
      bus.period_count = '0;
      bus.cancel = 1'b0;

      // 1: reset then a 3-period run, tick every 15 cycles
      cycle();
      cycle();
      checkEn = 1'b1;
      check("lit_reset_outs", {bus.start_ack, bus.busy, bus.done, bus.err_stall, timer_enable, timer_clear}, 0);
      check("lit_reset_rem", bus.remaining, 0);
      rst = 1'b1;
      cycle();
      startRun(3);
      check("lit_clear", timer_clear, 1);
      check("lit_rem3", bus.remaining, 3);
      cycle();
      check("lit_enable", timer_enable, 1);
      check("lit_clear_gone", timer_clear, 0);
      idleCycles(13);
      tickOnce();
      check("lit_rem2", bus.remaining, 2);
      idleCycles(14);
      tickOnce();
      check("lit_rem1", bus.remaining, 1);
      idleCycles(14);
      tickOnce();
      check("lit_done", bus.done, 1);
      check("lit_done_rem0", bus.remaining, 0);
      check("lit_done_en0", timer_enable, 0);
      cycle();
      check("lit_after_done", {bus.busy, bus.done}, 0);

      // 2: zero-period request completes without touching the timer
      idleCycles(2);
      startRun(0);
      check("lit_zero_done", bus.done, 1);
      check("lit_zero_timer", {timer_enable, timer_clear}, 0);
      cycle();
      check("lit_zero_idle", bus.busy, 0);

      // 3: cancel coincident with the 2nd tick of a 5-period run
      idleCycles(2);
      startRun(5);
      cycle();
      idleCycles(4);
      tickOnce();
      idleCycles(4);
      tick = 1'b1;
      bus.cancel = 1'b1;
      cycle();
      tick = 1'b0;
      bus.cancel = 1'b0;
      check("lit_cancel_rem", bus.remaining, 0);
      check("lit_cancel_busy", bus.busy, 0);
      cycle();
      check("lit_cancel_nodone", bus.done, 0);

      // 4: stall watchdog, no ticks at all
      idleCycles(2);
      startRun(2);
      cycle();
      n = 0;
      while (!bus.err_stall && n < 100) begin
         cycle();
         n++;
      end
      check("lit_stall_delay", n, GUARD);
      check("lit_stall_en0", timer_enable, 0);
      bus.start_req = 1'b1;
      bus.period_count = CNT'(1);
      for (int i = 0; i < 3; i++) begin
         cycle();
         check("lit_fault_noack", bus.start_ack, 0);
      end
      bus.start_req = 1'b0;
      bus.cancel = 1'b1;
      cycle();
      bus.cancel = 1'b0;
      check("lit_fault_clear", bus.err_stall, 0);

      // 5: start_req held high, N=1, random ticks including ARM/DONE
      idleCycles(2);
      acks = 0;
      dones = 0;
      bus.start_req = 1'b1;
      bus.period_count = CNT'(1);
      for (int i = 0; i < 150; i++) begin
         tick = ($urandom_range(0, 3) == 0);
         cycle();
         acks += int'(bus.start_ack);
         dones += int'(bus.done);
      end
      tick = 1'b0;
      bus.start_req = 1'b0;
      check("lit_b2b_runs", acks >= 3, 1);
      check("lit_b2b_balance", (acks - dones) <= 1 && (acks - dones) >= 0, 1);
      idleCycles(25);

      // 6: reset in mid-run with remaining=4
      startRun(5);
      cycle();
      idleCycles(3);
      tickOnce();
      check("lit_mid_rem4", bus.remaining, 4);
      rst = 1'b0;
      cycle();
      check("lit_midrst_outs", {bus.start_ack, bus.busy, bus.done, bus.err_stall, timer_enable, timer_clear}, 0);
      check("lit_midrst_rem", bus.remaining, 0);
      rst = 1'b1;
      cycle();
      startRun(2);
      cycle();
      idleCycles(5);
      tickOnce();
      idleCycles(5);
      tickOnce();
      check("lit_fresh_done", bus.done, 1);
      cycle();

      // random traffic; requester drops start_req on start_ack
      for (int i = 0; i < 3000; i++) begin
         if (!bus.start_req && $urandom_range(0, 5) == 0) begin
            bus.start_req = 1'b1;
            bus.period_count = CNT'($urandom_range(0, 6));
         end
         tick = ($urandom_range(0, 7) == 0);
         bus.cancel = ($urandom_range(0, 63) == 0);
         rst = !($urandom_range(0, 599) == 0);
         cycle();
         if (bus.start_ack) bus.start_req = 1'b0;
      end
      rst = 1'b1;
      tick = 1'b0;
      bus.cancel = 1'b0;
      bus.start_req = 1'b0;
      idleCycles(3);

      @(posedge clk);
      #1;
      checkEn = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
